// File: rtl/uart_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_responder_if
// Desc     : Client-side strobe and status signals of the UART bus responder.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_bus_responder_if;
    logic rdn;
    logic wrn;
    logic dataready;
    logic tbre;
    logic tsre;
    logic rx_overrun;

    modport master (
        output rdn,
        output wrn,
        input  dataready,
        input  tbre,
        input  tsre,
        input  rx_overrun
    );

    modport slave (
        input  rdn,
        input  wrn,
        output dataready,
        output tbre,
        output tsre,
        output rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_responder
// Desc     : 8N1 UART with a strobed 8-bit client bus. UART_RX_FIFO_EN selects
//            a 4-entry receive FIFO instead of a single holding byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_responder #(
    parameter int BAUD_DIV = 1152
) (
    input  wire                 clk,
    input  wire                 rst_n,
    uart_bus_responder_if.slave bus,
    inout  wire  [7:0]          data,
    output wire                 txd,
    input  wire                 rxd
);

    localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_half_last = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic        r_rdn_q;
    logic        r_wrn_q;
    logic        w_pop;
    logic        w_wr_accept;

    tx_state_t   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_tx_hold;
    logic        r_txd;
    logic        r_tbre;
    logic        r_tsre;
    logic        w_tx_tick;

    rx_state_t   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_sync1;
    logic        r_rx_sync2;
    logic        r_rx_prev;
    logic        r_rx_ferr;
    logic        w_rx_push;
    logic        w_rx_accept;
    logic        w_rx_avail;
    logic [7:0]  w_head;
    logic        r_rx_overrun;

    // ------------------------------------------------------------------------
    // Client bus strobes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdn_q <= 1'b1;
            r_wrn_q <= 1'b1;
        end else begin
            r_rdn_q <= bus.rdn;
            r_wrn_q <= bus.wrn;
        end
    end

    // A read in progress blocks any write strobe.
    assign w_pop       = bus.rdn & ~r_rdn_q & w_rx_avail;
    assign w_wr_accept = ~bus.wrn & r_wrn_q & bus.rdn & r_tbre;

    assign data           = (!bus.rdn && w_rx_avail) ? w_head : 8'hzz;
    assign bus.dataready  = w_rx_avail;
    assign bus.tbre       = r_tbre;
    assign bus.tsre       = r_tsre;
    assign bus.rx_overrun = r_rx_overrun;
    assign txd            = r_txd;

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    assign w_tx_tick = (r_tx_cnt == c_baud_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_hold  <= 8'd0;
            r_txd      <= 1'b1;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (!r_tbre) begin
                        r_tx_shift <= r_tx_hold;
                        r_tbre     <= 1'b1;
                        r_txd      <= 1'b0;
                        r_tx_cnt   <= 16'd0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= 16'd0;
                        r_tx_bit   <= 3'd0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= 16'd0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= 16'd0;
                        // A byte already waiting starts right away: no idle bit.
                        if (!r_tbre) begin
                            r_tx_shift <= r_tx_hold;
                            r_tbre     <= 1'b1;
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tsre     <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase

            // Placed last so a write on the final stop edge keeps tsre low.
            if (w_wr_accept) begin
                r_tx_hold <= data;
                r_tbre    <= 1'b0;
                r_tsre    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    assign w_rx_push = (r_rx_state == RX_STOP) && !r_rx_ferr &&
                       (r_rx_cnt == c_baud_last) && r_rx_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_sync1 <= rxd;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync2) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start re-check rejects short glitches.
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_baud_last) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_ferr) begin
                        if (r_rx_sync2) begin
                            r_rx_ferr  <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (r_rx_cnt == c_baud_last) begin
                        r_rx_cnt <= 16'd0;
                        if (r_rx_sync2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Receive storage
    // ------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;

    // When full, a pop on the same edge frees the slot being written.
    assign w_rx_avail  = (r_count != 3'd0);
    assign w_rx_accept = w_rx_push && ((r_count != 3'd4) || w_pop);
    assign w_head      = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_rx_accept) begin
            r_fifo[r_wr_ptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_count      <= 3'd0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_accept) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_rx_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_rx_push && !w_rx_accept) begin
                r_rx_overrun <= 1'b1;
            end
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_full;

    assign w_rx_avail  = r_full;
    assign w_rx_accept = w_rx_push && (!r_full || w_pop);
    assign w_head      = r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= 8'd0;
            r_full       <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_accept) begin
                r_hold <= r_rx_shift;
                r_full <= 1'b1;
            end else if (w_pop) begin
                r_full <= 1'b0;
            end
            if (w_rx_push && !w_rx_accept) begin
                r_rx_overrun <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
